// File: rtl/main_mem_mp_pkg.sv
// toy_mem_pkg: shared types and default geometry for the TOY main memory.
// Imported by the memory top, its interface and the bench.
package toy_mem_pkg;

  localparam int DW_DEF     = 16;
  localparam int AW_DEF     = 8;
  localparam int RPORTS_DEF = 2;

  typedef enum logic {
    MS_CLEAR,
    MS_RUN
  } mem_state_e;

  typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/main_mem_mp_if.sv
// main_mem_mp_if: rw port handshake plus RPORTS read-only ports.
// Signal names keep the memory-side _i/_o view.
interface main_mem_mp_if
  import toy_mem_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int RPORTS = RPORTS_DEF
) ();

  logic                          rw_ready_o;
  logic                          rw_val_i;
  logic                          rw_wen_i;
  logic [AW-1:0]                 rw_addr_i;
  logic [DW-1:0]                 rw_wdata_i;
  logic [DW-1:0]                 rw_rdata_o;
  logic                          rw_rvalid_o;
  logic [RPORTS-1:0]             r_val_i;
  logic [RPORTS-1:0][AW-1:0]     r_addr_i;
  logic [RPORTS-1:0][DW-1:0]     r_rdata_o;
  logic [RPORTS-1:0]             r_rvalid_o;

  modport master (
    input  rw_ready_o,
    output rw_val_i,
    output rw_wen_i,
    output rw_addr_i,
    output rw_wdata_i,
    input  rw_rdata_o,
    input  rw_rvalid_o,
    output r_val_i,
    output r_addr_i,
    input  r_rdata_o,
    input  r_rvalid_o
  );

  modport slave (
    output rw_ready_o,
    input  rw_val_i,
    input  rw_wen_i,
    input  rw_addr_i,
    input  rw_wdata_i,
    output rw_rdata_o,
    output rw_rvalid_o,
    input  r_val_i,
    input  r_addr_i,
    output r_rdata_o,
    output r_rvalid_o
  );

endinterface

// File: rtl/main_mem_mp_bank.sv
// mem_bank: 2^AW x DW array, one write/read port (A) and one read port (B).
// Both reads are registered; B can return the same-cycle write data.
module mem_bank #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          a_re_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_re_i,
  input  logic          b_fwd_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[a_addr_i] <= wdata_i;
    end
  end

  // Array has no reset; only the read registers do.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i) begin
        a_rdata_q <= mem_q[a_addr_i];
      end
      if (b_re_i) begin
        b_rdata_q <= b_fwd_i ? wdata_i : mem_q[b_addr_i];
      end
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/main_mem_mp.sv
// main_mem_mp: multi-port TOY main memory with a self-clear FSM.
// RPORTS bank replicas share every write; read port i owns replica i.
module main_mem_mp
  import toy_mem_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int RPORTS = RPORTS_DEF,
  parameter int FWD    = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_req_i,
  output logic         clr_busy_o,
  main_mem_mp_if.slave bus
);

  localparam bit FwdEn = (FWD != 0);

  mem_state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic run;
  logic rw_acc;
  logic rw_wr;
  logic rw_rd;
  logic we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [RPORTS-1:0] r_re;
  logic [RPORTS-1:0] fwd;
  logic rw_rvalid_q;
  logic [RPORTS-1:0] r_rvalid_q;
  logic [RPORTS-1:0][DW-1:0] a_rd;
  logic [RPORTS-1:0][DW-1:0] b_rd;
  logic unused_a_rd;

  assign run            = rst_ni && (state_q == MS_RUN);
  assign clr_busy_o     = !run;
  assign bus.rw_ready_o = run && !clr_req_i;

  assign rw_acc = bus.rw_val_i && bus.rw_ready_o;
  assign rw_wr  = rw_acc && bus.rw_wen_i;
  assign rw_rd  = rw_acc && !bus.rw_wen_i;

  // Clear pass owns the write port; reset itself never writes.
  assign we    = rst_ni && (!run || rw_wr);
  assign waddr = run ? bus.rw_addr_i : ptr_q;
  assign wdata = run ? bus.rw_wdata_i : '0;
  assign r_re  = run ? bus.r_val_i : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      MS_CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (&ptr_q) begin
          state_d = MS_RUN;
        end
      end
      MS_RUN: begin
        if (clr_req_i) begin
          state_d = MS_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = MS_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= MS_CLEAR;
      ptr_q       <= '0;
      rw_rvalid_q <= 1'b0;
      r_rvalid_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rw_rvalid_q <= rw_rd;
      r_rvalid_q  <= r_re;
    end
  end

  for (genvar i = 0; i < RPORTS; i++) begin : g_bank
    assign fwd[i] = FwdEn && rw_wr &&
                    (bus.r_addr_i[i] == bus.rw_addr_i);

    mem_bank #(
      .DW(DW),
      .AW(AW)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .we_i     (we),
      .a_addr_i (waddr),
      .wdata_i  (wdata),
      .a_re_i   (rw_rd),
      .a_rdata_o(a_rd[i]),
      .b_re_i   (r_re[i]),
      .b_fwd_i  (fwd[i]),
      .b_addr_i (bus.r_addr_i[i]),
      .b_rdata_o(b_rd[i])
    );
  end

  // Only replica 0 drives the rw read path.
  assign unused_a_rd     = ^a_rd;
  assign bus.rw_rdata_o  = a_rd[0];
  assign bus.rw_rvalid_o = rw_rvalid_q;
  assign bus.r_rdata_o   = b_rd;
  assign bus.r_rvalid_o  = r_rvalid_q;

endmodule

// File: tb/tb_main_mem_mp.sv
// tb_main_mem_mp: directed vector bench for main_mem_mp.
// Drives FWD=1 and FWD=0 instances in lockstep plus an AW=4/DW=32/RPORTS=4 one.
module tb_main_mem_mp;
  import toy_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a;
  logic clr_c;
  logic busy_a, busy_b, busy_c;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  main_mem_mp_if #(.DW(16), .AW(8), .RPORTS(2)) ifa ();
  main_mem_mp_if #(.DW(16), .AW(8), .RPORTS(2)) ifb ();
  main_mem_mp_if #(.DW(32), .AW(4), .RPORTS(4)) ifc ();

  main_mem_mp #(.FWD(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_a),
    .clr_busy_o(busy_a), .bus(ifa)
  );
  main_mem_mp #(.FWD(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_a),
    .clr_busy_o(busy_b), .bus(ifb)
  );
  main_mem_mp #(.DW(32), .AW(4), .RPORTS(4), .FWD(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_c),
    .clr_busy_o(busy_c), .bus(ifc)
  );

  always_comb begin
    ifb.rw_val_i   = ifa.rw_val_i;
    ifb.rw_wen_i   = ifa.rw_wen_i;
    ifb.rw_addr_i  = ifa.rw_addr_i;
    ifb.rw_wdata_i = ifa.rw_wdata_i;
    ifb.r_val_i    = ifa.r_val_i;
    ifb.r_addr_i   = ifa.r_addr_i;
  end

  typedef struct {
    logic       val;
    logic       wen;
    logic [7:0] addr;
    word_t      wd;
    logic [1:0] rv;
    logic [7:0] ra0;
    logic [7:0] ra1;
    logic       e_rwv;
    word_t      e_rw;
    logic [1:0] e_rv;
    word_t      e_r0;
    word_t      e_r0b;
    word_t      e_r1;
  } vec_t;

  vec_t vt[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_a();
    ifa.rw_val_i   = 1'b0;
    ifa.rw_wen_i   = 1'b0;
    ifa.rw_addr_i  = '0;
    ifa.rw_wdata_i = '0;
    ifa.r_val_i    = '0;
    ifa.r_addr_i   = '0;
  endtask

  task automatic wait_ready_a(output int cyc, output int pulses);
    cyc    = 0;
    pulses = 0;
    while (!ifa.rw_ready_o && cyc < 400) begin
      step();
      cyc++;
      if (ifa.rw_rvalid_o || (|ifa.r_rvalid_o) ||
          ifb.rw_rvalid_o || (|ifb.r_rvalid_o))
        pulses++;
    end
  endtask

  task automatic wr_a(input logic [7:0] a, input word_t d);
    ifa.rw_val_i   = 1'b1;
    ifa.rw_wen_i   = 1'b1;
    ifa.rw_addr_i  = a;
    ifa.rw_wdata_i = d;
    step();
    idle_a();
  endtask

  initial begin
    int cyc;
    int pulses;
    int c_cyc;
    int bad;
    logic [3:0]  ca[4];
    logic [31:0] cd[4];

    vt[0] = '{1'b1, 1'b1, 8'h12, 16'hBEEF, 2'b00, 8'h00, 8'h00,
              1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 8'h12, 16'h0000, 2'b10, 8'h00, 8'h12,
              1'b1, 16'hBEEF, 2'b10, 16'h0000, 16'h0000, 16'hBEEF};
    vt[2] = '{1'b1, 1'b1, 8'h40, 16'hBEEF, 2'b00, 8'h00, 8'h00,
              1'b0, 16'hBEEF, 2'b00, 16'h0000, 16'h0000, 16'hBEEF};
    vt[3] = '{1'b1, 1'b1, 8'h40, 16'h1234, 2'b01, 8'h40, 8'h00,
              1'b0, 16'hBEEF, 2'b01, 16'h1234, 16'hBEEF, 16'hBEEF};
    vt[4] = '{1'b1, 1'b0, 8'h40, 16'h0000, 2'b11, 8'h40, 8'h40,
              1'b1, 16'h1234, 2'b11, 16'h1234, 16'h1234, 16'h1234};
    vt[5] = '{1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00,
              1'b0, 16'h1234, 2'b00, 16'h1234, 16'h1234, 16'h1234};
    vt[6] = '{1'b1, 1'b1, 8'hFF, 16'hA5A5, 2'b11, 8'hFF, 8'h00,
              1'b0, 16'h1234, 2'b11, 16'hA5A5, 16'h0000, 16'h0000};
    vt[7] = '{1'b1, 1'b0, 8'h00, 16'h0000, 2'b11, 8'hFF, 8'h12,
              1'b1, 16'h0000, 2'b11, 16'hA5A5, 16'hA5A5, 16'hBEEF};

    ca = '{4'h1, 4'h5, 4'h9, 4'hF};
    cd = '{32'h0000_0011, 32'hCAFE_0055, 32'h1234_5699, 32'hFFFF_00FF};

    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_c = 1'b0;
    idle_a();
    ifc.rw_val_i   = 1'b0;
    ifc.rw_wen_i   = 1'b0;
    ifc.rw_addr_i  = '0;
    ifc.rw_wdata_i = '0;
    ifc.r_val_i    = '0;
    ifc.r_addr_i   = '0;
    repeat (3) step();

    chk("rst_busy", busy_a, 1'b1);
    chk("rst_ready", ifa.rw_ready_o, 1'b0);
    chk("rst_rw_rvalid", ifa.rw_rvalid_o, 1'b0);
    chk("rst_r_rvalid", ifa.r_rvalid_o, 2'b00);
    chk("rst_r_rdata", ifa.r_rdata_o, 32'h0);
    chk("rst_busy_c", busy_c, 1'b1);

    // Release with requests pending; the clear must ignore them.
    rst_n         = 1'b1;
    ifa.rw_val_i  = 1'b1;
    ifa.r_val_i   = 2'b11;
    c_cyc  = 0;
    cyc    = 0;
    pulses = 0;
    while (!ifa.rw_ready_o && cyc < 400) begin
      step();
      cyc++;
      if (ifa.rw_rvalid_o || (|ifa.r_rvalid_o) ||
          ifb.rw_rvalid_o || (|ifb.r_rvalid_o))
        pulses++;
      if (ifc.rw_ready_o && c_cyc == 0) c_cyc = cyc;
    end
    idle_a();
    chk("init_clear_cycles", cyc, 256);
    chk("init_clear_pulses", pulses, 0);
    chk("init_clear_cycles_c", c_cyc, 16);
    chk("init_busy_low", busy_a, 1'b0);

    foreach (vt[k]) begin
      ifa.rw_val_i    = vt[k].val;
      ifa.rw_wen_i    = vt[k].wen;
      ifa.rw_addr_i   = vt[k].addr;
      ifa.rw_wdata_i  = vt[k].wd;
      ifa.r_val_i     = vt[k].rv;
      ifa.r_addr_i[0] = vt[k].ra0;
      ifa.r_addr_i[1] = vt[k].ra1;
      step();
      chk($sformatf("v%0d rw_rvalid", k), ifa.rw_rvalid_o, vt[k].e_rwv);
      chk($sformatf("v%0d rw_rdata", k), ifa.rw_rdata_o, vt[k].e_rw);
      chk($sformatf("v%0d r_rvalid", k), ifa.r_rvalid_o, vt[k].e_rv);
      chk($sformatf("v%0d r0_fwd1", k), ifa.r_rdata_o[0], vt[k].e_r0);
      chk($sformatf("v%0d r1", k), ifa.r_rdata_o[1], vt[k].e_r1);
      chk($sformatf("v%0d r0_fwd0", k), ifb.r_rdata_o[0], vt[k].e_r0b);
      chk($sformatf("v%0d rw_rdata_b", k), ifb.rw_rdata_o, vt[k].e_rw);
    end
    idle_a();

    // Clear request collides with a write: the write is refused.
    ifa.rw_val_i   = 1'b1;
    ifa.rw_wen_i   = 1'b1;
    ifa.rw_addr_i  = 8'h12;
    ifa.rw_wdata_i = 16'h7777;
    clr_a          = 1'b1;
    #1;
    chk("clr_ready_low", ifa.rw_ready_o, 1'b0);
    step();
    clr_a = 1'b0;
    idle_a();
    ifa.r_val_i     = 2'b11;
    ifa.r_addr_i[0] = 8'hFF;
    ifa.r_addr_i[1] = 8'hFF;
    chk("clr_busy_a", busy_a, 1'b1);
    chk("clr_busy_b", busy_b, 1'b1);
    wait_ready_a(cyc, pulses);
    idle_a();
    chk("clr_cycles", cyc, 256);
    chk("clr_pulses", pulses, 0);
    chk("clr_hold_r0", ifa.r_rdata_o[0], 16'hA5A5);
    chk("clr_hold_r1", ifa.r_rdata_o[1], 16'hBEEF);

    bad = 0;
    for (int a = 0; a < 256; a++) begin
      ifa.rw_val_i    = 1'b1;
      ifa.rw_wen_i    = 1'b0;
      ifa.rw_addr_i   = 8'(a);
      ifa.r_val_i     = 2'b11;
      ifa.r_addr_i[0] = 8'(a);
      ifa.r_addr_i[1] = 8'(255 - a);
      step();
      if (!ifa.rw_rvalid_o || ifa.r_rvalid_o != 2'b11 ||
          ifa.rw_rdata_o != 16'h0 || ifa.r_rdata_o != 32'h0 ||
          !ifb.rw_rvalid_o || ifb.r_rvalid_o != 2'b11 ||
          ifb.rw_rdata_o != 16'h0 || ifb.r_rdata_o != 32'h0)
        bad++;
    end
    idle_a();
    chk("clr_sweep_bad", bad, 0);

    // Reset partway through a clear restarts the pass from address 0.
    wr_a(8'h00, 16'hFFFF);
    wr_a(8'h7F, 16'hFFFF);
    wr_a(8'hFF, 16'hFFFF);
    ifa.rw_val_i    = 1'b1;
    ifa.rw_addr_i   = 8'h7F;
    ifa.r_val_i     = 2'b11;
    ifa.r_addr_i[0] = 8'hFF;
    ifa.r_addr_i[1] = 8'h00;
    step();
    idle_a();
    chk("pre_rw", ifa.rw_rdata_o, 16'hFFFF);
    chk("pre_r0", ifa.r_rdata_o[0], 16'hFFFF);
    chk("pre_r1", ifa.r_rdata_o[1], 16'hFFFF);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    repeat (100) step();
    chk("mid_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    step();
    step();
    chk("mid_rst_rw_rdata", ifa.rw_rdata_o, 16'h0);
    chk("mid_rst_r_rdata", ifa.r_rdata_o, 32'h0);
    chk("mid_rst_ready", ifa.rw_ready_o, 1'b0);
    chk("mid_rst_busy", busy_a, 1'b1);
    ifa.rw_val_i    = 1'b1;
    ifa.rw_addr_i   = 8'h7F;
    ifa.r_val_i     = 2'b11;
    ifa.r_addr_i[0] = 8'h00;
    ifa.r_addr_i[1] = 8'hFF;
    rst_n = 1'b1;
    wait_ready_a(cyc, pulses);
    chk("restart_cycles", cyc, 256);
    chk("restart_pulses", pulses, 0);
    step();
    idle_a();
    chk("post_rw_rvalid", ifa.rw_rvalid_o, 1'b1);
    chk("post_rw_7f", ifa.rw_rdata_o, 16'h0);
    chk("post_r_rvalid", ifa.r_rvalid_o, 2'b11);
    chk("post_r0_00", ifa.r_rdata_o[0], 16'h0);
    chk("post_r1_ff", ifa.r_rdata_o[1], 16'h0);

    // Small configuration: clear length and four concurrent readers.
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    cyc   = 0;
    while (!ifc.rw_ready_o && cyc < 100) begin
      step();
      cyc++;
    end
    chk("c_clear_cycles", cyc, 16);
    for (int k = 0; k < 4; k++) begin
      ifc.rw_val_i   = 1'b1;
      ifc.rw_wen_i   = 1'b1;
      ifc.rw_addr_i  = ca[k];
      ifc.rw_wdata_i = cd[k];
      step();
    end
    for (int j = 0; j < 2; j++) begin
      ifc.rw_val_i  = 1'b1;
      ifc.rw_wen_i  = 1'b0;
      ifc.rw_addr_i = 4'h3;
      ifc.r_val_i   = 4'hF;
      for (int p = 0; p < 4; p++) ifc.r_addr_i[p] = ca[(p + j) % 4];
      step();
      chk($sformatf("c%0d rvalid", j), ifc.r_rvalid_o, 4'hF);
      chk($sformatf("c%0d rw_3", j), ifc.rw_rdata_o, 32'h0);
      for (int p = 0; p < 4; p++)
        chk($sformatf("c%0d port%0d", j, p), ifc.r_rdata_o[p],
            cd[(p + j) % 4]);
    end
    ifc.rw_val_i = 1'b0;
    ifc.r_val_i  = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/main_mem_mp.md
# main_mem_mp

Parametrised successor to the TOY main memory. It provides one read/write port and `RPORTS` independent read-only ports over a single logical word-addressed store. It adds an explicit self-clear state machine with busy/ready signalling, a software-triggered clear, and optional same-cycle write-to-read forwarding. It sits between the TOY core's fetch/operand read paths and its load/store unit.

## Interface

Parameters:
- `DW`, 16, data word width.
- `AW`, 8, address width; depth = 2^AW words.
- `RPORTS`, 2, number of read-only ports (≥1).
- `FWD`, 1, 1 = read ports return write data on a same-cycle address match; 0 = old data.

Ports:
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_ni` in 1: **synchronous, active-low reset** (sampled on `clk_i`).
- `clr_req_i` in 1: request a full clear; acted on only in RUN.
- `clr_busy_o` out 1: high while in CLEAR.
- `rw_ready_o` out 1: combinational, `state==RUN && !clr_req_i`.
- `rw_val_i` in 1: rw request valid; accepted when `rw_val_i && rw_ready_o`.
- `rw_wen_i` in 1: 1 = write, 0 = read.
- `rw_addr_i` in AW: rw address.
- `rw_wdata_i` in DW: write data.
- `rw_rdata_o` out DW: rw read data.
- `rw_rvalid_o` out 1: one-cycle pulse, `rw_rdata_o` updated.
- `r_val_i` in RPORTS: per-port read request.
- `r_addr_i` in RPORTS×AW: per-port address, packed as `[RPORTS-1:0][AW-1:0]`.
- `r_rdata_o` out RPORTS×DW: per-port read data.
- `r_rvalid_o` out RPORTS: per-port one-cycle pulse.

## Operation

- FSM has two states.
  - CLEAR: write 0 to address `ptr` every cycle, then `ptr++`.
    - When `ptr == 2^AW-1` is written, go to RUN; `ptr` wraps to 0.
  - RUN: serve requests.
    - If `clr_req_i` is high, go to CLEAR with `ptr=0`; no rw request is accepted that cycle.
- Reset while `rst_ni` is low:
  - state=CLEAR, `ptr`=0.
  - `rw_rdata_o`, `r_rdata_o`, `rw_rvalid_o` and `r_rvalid_o` = 0.
  - `clr_busy_o`=1, `rw_ready_o`=0.
  - Reset mid-clear restarts at address 0.
  - Array contents are not touched by reset itself; the CLEAR pass zeroes them.
- During CLEAR:
  - All `r_val_i` and `rw_val_i` are ignored.
  - Every rvalid stays 0; rdata outputs hold their previous value.
- rw read: `rw_rdata_o <= mem[rw_addr_i]`, `rw_rvalid_o` pulses.
- rw write: `mem[rw_addr_i] <= rw_wdata_i`.
  - `rw_rdata_o` holds its value; `rw_rvalid_o`=0.
- Read port i: when `r_val_i[i]` is high in RUN, `r_rdata_o[i] <= mem[r_addr_i[i]]` and `r_rvalid_o[i]` pulses.
  - Requests are never back-pressured.
- Same-cycle write plus port-i read to the same address:
  - `FWD=1` returns `rw_wdata_i`.
  - `FWD=0` returns the pre-write value.
- Multiple read ports on the same address are all served identically.
- Rdata outputs hold their last value until the next accepted read on that port.

## Timing

- Read latency is 1 cycle for all ports: request at edge n, data and rvalid valid after edge n.
- Write is visible to any read issued at edge n+1 or later.
- Clear takes exactly 2^AW cycles.
  - Counting from the first edge with `rst_ni` high (edge 0), `rw_ready_o` is first high after edge 2^AW-1.
  - That is 256 cycles at default `AW`.
- `clr_req_i` sampled high at edge n in RUN: `clr_busy_o` high from edge n until after edge n+2^AW.
- Read ports have no dependency on `rw_ready_o`; they are gated only by state.

## Structure

- Shared package `toy_mem_pkg`:
  - Default `DW`/`AW`/`RPORTS` constants.
  - State enum `mem_state_e {MS_CLEAR, MS_RUN}`.
  - `word_t` typedef.
- Sub-module `mem_bank`: 2^AW×DW array with one write/read port and one read-only port, each with a registered read.
- The top instantiates `RPORTS` replicas of `mem_bank`.
  - All replicas receive identical writes: the clear writes or the rw writes.
  - The rw read path comes from replica 0.
  - Read port i reads replica i.
- The top holds the FSM, `ptr`, the write mux and the forwarding compare.

## Test plan

- Release reset with memory preloaded by a backdoor write of 0xFFFF everywhere → `clr_busy_o` drops after 256 cycles; reading addresses 0x00, 0x7F and 0xFF on every port returns 0x0000.
- rw write 0xBEEF to 0x12, then rw read 0x12 and port 1 read 0x12 in the next cycle → both return 0xBEEF one cycle later with rvalid pulses.
- Same-cycle rw write 0x1234 to 0x40 and port 0 read 0x40 → returns 0x1234 with `FWD=1`, the old value 0xBEEF with `FWD=0`.
- `clr_req_i` pulsed while `rw_val_i` is high → `rw_ready_o`=0 that cycle, the write is not performed, and after 256 cycles the whole array reads 0.
- Assert `rst_ni` low at clear cycle 100, release, and issue requests during the clear → no rvalid pulses; clear restarts at 0 and completes exactly 256 cycles after release.
- Configuration `AW=4`, `DW=32`, `RPORTS=4`: all four ports read distinct addresses each cycle after writes → correct data on every port, and clear takes 16 cycles.
